// File: rtl/block_mac_pkg.sv
// Shared types and constants for the 2x2 block multiply-accumulate.
// Holds the FSM state enum, operand width, step count, fixed latency and the
// per-step operand/target select tables used to sequence the shared multiplier.
// Optional feature macro: BLOCK_MAC_SAT_EN (saturating arithmetic + ovf flag).
package block_mac_pkg;

   localparam int unsigned DATA_W      = 32;
   localparam int unsigned PROD_W      = 2 * DATA_W;
   localparam int unsigned N_STEPS     = 8;
   localparam int unsigned STEP_W      = 3;
   localparam int unsigned MAC_LATENCY = 10;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_MUL   = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   // Saturation limits (only referenced when saturation is built in).
   localparam logic signed [DATA_W-1:0] S_MAX = {1'b0, {(DATA_W-1){1'b1}}};
   localparam logic signed [DATA_W-1:0] S_MIN = {1'b1, {(DATA_W-1){1'b0}}};

   // Per-step 2-bit selects packed step7..step0 (MSB..LSB).
   // Operand index: 0=x_11, 1=x_12, 2=x_21, 3=x_22. Target index: 0=c11..3=c22.
   localparam logic [15:0] A_SEL = {2'd3, 2'd2, 2'd3, 2'd2, 2'd1, 2'd0, 2'd1, 2'd0};
   localparam logic [15:0] B_SEL = {2'd3, 2'd1, 2'd2, 2'd0, 2'd3, 2'd1, 2'd2, 2'd0};
   localparam logic [15:0] T_SEL = {2'd3, 2'd3, 2'd2, 2'd2, 2'd1, 2'd1, 2'd0, 2'd0};

   // Extract the 2-bit select for a given step from a packed table.
   function automatic logic [1:0] step_sel(input logic [15:0] tbl,
                                           input logic [STEP_W-1:0] step);
      return tbl[{step, 1'b0} +: 2];
   endfunction

endpackage

// File: rtl/block_mac_2x2_if.sv
// Operand/result bundle between the matrix control unit (master) and the
// 2x2 block MAC (slave).
//   start          : operation request level, rising edge acted on
//   a_xx, b_xx     : A/B block operands, signed DATA_W
//   c_xx           : result block, signed DATA_W, held between completions
//   done           : one-cycle completion pulse (done_mac)
//   busy           : operation in progress
//   ovf            : saturation occurred in last operation (0 without BLOCK_MAC_SAT_EN)
interface block_mac_2x2_if;
   import block_mac_pkg::*;

   logic                     start;
   logic signed [DATA_W-1:0] a_11, a_12, a_21, a_22;
   logic signed [DATA_W-1:0] b_11, b_12, b_21, b_22;
   logic signed [DATA_W-1:0] c_11, c_12, c_21, c_22;
   logic                     done;
   logic                     busy;
   logic                     ovf;

   modport master (
      output start, a_11, a_12, a_21, a_22, b_11, b_12, b_21, b_22,
      input  c_11, c_12, c_21, c_22, done, busy, ovf
   );

   modport slave (
      input  start, a_11, a_12, a_21, a_22, b_11, b_12, b_21, b_22,
      output c_11, c_12, c_21, c_22, done, busy, ovf
   );

endinterface

// File: rtl/block_mac_2x2_mul_stage.sv
// mul_stage: registered signed DATA_W x DATA_W multiplier with a one-stage
// pipeline carrying the step's accumulate target and load/add flag.
// Macro BLOCK_MAC_SAT_EN: product saturates to DATA_W and o_sat flags it;
// otherwise the product is truncated to its low DATA_W bits and o_sat is 0.
//   clk, rst        : clock, synchronous active-low reset
//   i_vld/i_tgt/i_load, i_a/i_b : issued step and operands
//   o_vld/o_tgt/o_load, o_p     : registered product with its step tags
//   o_sat           : registered product-saturation flag
module mul_stage
   import block_mac_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_vld,
   input  logic [1:0]               i_tgt,
   input  logic                     i_load,
   input  logic signed [DATA_W-1:0] i_a,
   input  logic signed [DATA_W-1:0] i_b,
   output logic                     o_vld,
   output logic [1:0]               o_tgt,
   output logic                     o_load,
   output logic signed [DATA_W-1:0] o_p,
   output logic                     o_sat
);

   logic                     r_vld, r_load;
   logic [1:0]               r_tgt;
   logic signed [DATA_W-1:0] r_p;
   logic signed [DATA_W-1:0] w_p;

`ifdef BLOCK_MAC_SAT_EN
   logic signed [PROD_W-1:0] w_full;
   logic                     w_sat;
   logic                     r_sat;

   // Full-width signed product, clamped when it leaves the DATA_W range.
   assign w_full = PROD_W'(i_a) * PROD_W'(i_b);
   assign w_sat  = (w_full > PROD_W'(S_MAX)) || (w_full < PROD_W'(S_MIN));
   assign w_p    = w_sat ? (w_full[PROD_W-1] ? S_MIN : S_MAX) : w_full[DATA_W-1:0];

   always_ff @(posedge clk) begin
      if (!rst) r_sat <= 1'b0;
      else      r_sat <= i_vld & w_sat;
   end
   assign o_sat = r_sat;
`else
   // Low DATA_W bits of the signed product.
   assign w_p   = i_a * i_b;
   assign o_sat = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_vld  <= 1'b0;
         r_tgt  <= 2'd0;
         r_load <= 1'b0;
         r_p    <= '0;
      end else begin
         r_vld  <= i_vld;
         r_tgt  <= i_tgt;
         r_load <= i_load;
         r_p    <= w_p;
      end
   end

   assign o_vld  = r_vld;
   assign o_tgt  = r_tgt;
   assign o_load = r_load;
   assign o_p    = r_p;

endmodule

// File: rtl/block_mac_2x2.sv
// block_mac_2x2: computes C = A*B for 2x2 signed blocks with one shared,
// time-multiplexed multiplier. Fixed 10-cycle start-to-done latency.
//   clk    : rising-edge clock
//   rst    : synchronous active-low reset
//   io_mac : slave side of block_mac_2x2_if (start, a/b in; c, done, busy, ovf out)
// Macro BLOCK_MAC_SAT_EN: saturating products/sums and a sticky ovf flag.
module block_mac_2x2
   import block_mac_pkg::*;
(
   input  logic           clk,
   input  logic           rst,
   block_mac_2x2_if.slave io_mac
);

   state_t                   r_state, w_state_nxt;
   logic                     r_start_q;
   logic [STEP_W-1:0]        r_step;
   logic signed [DATA_W-1:0] r_op_a [4];
   logic signed [DATA_W-1:0] r_op_b [4];
   logic signed [DATA_W-1:0] r_acc  [4];
   logic signed [DATA_W-1:0] r_c    [4];
   logic                     r_done, r_busy, r_ovf;

   logic                     w_accept, w_issue;
   logic                     w_p_vld, w_p_load, w_p_sat;
   logic [1:0]               w_p_tgt;
   logic signed [DATA_W-1:0] w_p, w_acc_cur, w_sum;
   logic                     w_sum_sat;

   // State register.
   always_ff @(posedge clk) begin
      if (!rst) r_state <= S_IDLE;
      else      r_state <= w_state_nxt;
   end

   // Next state; accept only on a start rising edge seen while idle.
   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_issue     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (io_mac.start && !r_start_q) begin
               w_accept    = 1'b1;
               w_state_nxt = S_MUL;
            end
         end
         S_MUL: begin
            w_issue = 1'b1;
            if (r_step == STEP_W'(N_STEPS - 1)) w_state_nxt = S_DRAIN;
         end
         S_DRAIN: w_state_nxt = S_DONE;
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   mul_stage u_mul (
      .clk    (clk),
      .rst    (rst),
      .i_vld  (w_issue),
      .i_tgt  (step_sel(T_SEL, r_step)),
      .i_load (~r_step[0]),
      .i_a    (r_op_a[step_sel(A_SEL, r_step)]),
      .i_b    (r_op_b[step_sel(B_SEL, r_step)]),
      .o_vld  (w_p_vld),
      .o_tgt  (w_p_tgt),
      .o_load (w_p_load),
      .o_p    (w_p),
      .o_sat  (w_p_sat)
   );

   // Pair sum for odd steps: wraps, or clamps on signed overflow.
   assign w_acc_cur = r_acc[w_p_tgt];
`ifdef BLOCK_MAC_SAT_EN
   logic signed [DATA_W-1:0] w_raw;
   assign w_raw     = w_acc_cur + w_p;
   assign w_sum_sat = (w_acc_cur[DATA_W-1] == w_p[DATA_W-1]) &&
                      (w_raw[DATA_W-1] != w_p[DATA_W-1]);
   assign w_sum     = w_sum_sat ? (w_p[DATA_W-1] ? S_MIN : S_MAX) : w_raw;
`else
   assign w_sum     = w_acc_cur + w_p;
   assign w_sum_sat = 1'b0;
`endif

   // Edge detect, operand capture, step counter, accumulators and outputs.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_start_q <= 1'b0;
         r_step    <= '0;
         r_done    <= 1'b0;
         r_busy    <= 1'b0;
         r_ovf     <= 1'b0;
         for (int i = 0; i < 4; i++) begin
            r_op_a[i] <= '0;
            r_op_b[i] <= '0;
            r_acc[i]  <= '0;
            r_c[i]    <= '0;
         end
      end else begin
         r_start_q <= io_mac.start;
         r_done    <= (r_state == S_DONE);

         if (w_accept) begin
            r_op_a[0] <= io_mac.a_11;
            r_op_a[1] <= io_mac.a_12;
            r_op_a[2] <= io_mac.a_21;
            r_op_a[3] <= io_mac.a_22;
            r_op_b[0] <= io_mac.b_11;
            r_op_b[1] <= io_mac.b_12;
            r_op_b[2] <= io_mac.b_21;
            r_op_b[3] <= io_mac.b_22;
            r_step    <= '0;
            r_ovf     <= 1'b0;
         end else if (w_issue) begin
            r_step <= r_step + STEP_W'(1);
         end

         // Even steps load the target, odd steps add into it.
         if (w_p_vld) begin
            r_acc[w_p_tgt] <= w_p_load ? w_p : w_sum;
            if (w_p_sat || (!w_p_load && w_sum_sat)) r_ovf <= 1'b1;
         end

         if (r_state == S_DONE) r_c <= r_acc;

         // busy spans acceptance through the done-pulse cycle.
         if (w_accept)    r_busy <= 1'b1;
         else if (r_done) r_busy <= 1'b0;
      end
   end

   assign io_mac.c_11 = r_c[0];
   assign io_mac.c_12 = r_c[1];
   assign io_mac.c_21 = r_c[2];
   assign io_mac.c_22 = r_c[3];
   assign io_mac.done = r_done;
   assign io_mac.busy = r_busy;
   assign io_mac.ovf  = r_ovf;

endmodule

// File: tb/tb_block_mac_2x2.sv
// Directed bench for block_mac_2x2: vector table of 2x2 operand blocks with
// hand-computed results, plus held-start/back-to-back and mid-op reset sequences.
module tb_block_mac_2x2;
   import block_mac_pkg::*;

   typedef struct {
      string nm;
      int    a [4];   // a11, a12, a21, a22
      int    b [4];   // b11, b12, b21, b22
      int    c [4];   // expected c11, c12, c21, c22
      bit    ovf;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_tests = 0;
   int   n_fail  = 0;
   vec_t vecs [5];

   block_mac_2x2_if u_if ();

   block_mac_2x2 dut (
      .clk    (clk),
      .rst    (rst),
      .io_mac (u_if)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)",
                  nm, $signed(act), act, $signed(exp), exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ops(input vec_t v);
      u_if.a_11 = v.a[0]; u_if.a_12 = v.a[1]; u_if.a_21 = v.a[2]; u_if.a_22 = v.a[3];
      u_if.b_11 = v.b[0]; u_if.b_12 = v.b[1]; u_if.b_21 = v.b[2]; u_if.b_22 = v.b[3];
   endtask

   task automatic chk_c(input string nm, input vec_t v);
      chk({nm, ".c11"}, u_if.c_11, v.c[0]);
      chk({nm, ".c12"}, u_if.c_12, v.c[1]);
      chk({nm, ".c21"}, u_if.c_21, v.c[2]);
      chk({nm, ".c22"}, u_if.c_22, v.c[3]);
   endtask

   // One isolated operation: latency, held outputs, result, busy/done shape.
   task automatic run_op(input vec_t v);
      logic [31:0] h [4];
      bit          moved;
      int          lat;
      h = '{u_if.c_11, u_if.c_12, u_if.c_21, u_if.c_22};
      set_ops(v);
      u_if.start = 1'b1;
      tick();                               // edge N: accepted
      u_if.start = 1'b0;
      chk({v.nm, ".busy_acc"}, 32'(u_if.busy), 32'd1);
      lat   = 0;
      moved = 1'b0;
      while (!u_if.done && lat < 20) begin
         if (u_if.c_11 !== h[0] || u_if.c_12 !== h[1] ||
             u_if.c_21 !== h[2] || u_if.c_22 !== h[3]) moved = 1'b1;
         tick();
         lat++;
      end
      chk({v.nm, ".latency"}, 32'(lat), 32'(MAC_LATENCY));
      chk({v.nm, ".c_held"}, 32'(moved), 32'd0);
      chk_c(v.nm, v);
      chk({v.nm, ".ovf"}, 32'(u_if.ovf), 32'(v.ovf));
      chk({v.nm, ".busy_done"}, 32'(u_if.busy), 32'd1);
      tick();                               // edge N+11
      chk({v.nm, ".done_pulse"}, 32'(u_if.done), 32'd0);
      chk({v.nm, ".busy_end"}, 32'(u_if.busy), 32'd0);
   endtask

   initial begin
      int  n_done, d0, d1;
      bit  moved;

      vecs[0] = '{"ident",  '{1, 0, 0, 1},  '{5, 6, 7, 8},   '{5, 6, 7, 8},     1'b0};
      vecs[1] = '{"signed", '{2, -3, 4, 1}, '{-1, 2, 5, -6}, '{-17, 22, 1, 2},  1'b0};
      vecs[3] = '{"plain",  '{3, 4, 5, 6},  '{7, 8, 9, 10},  '{57, 64, 89, 100}, 1'b0};
`ifdef BLOCK_MAC_SAT_EN
      vecs[2] = '{"ovf_mul", '{32'h7fffffff, 0, 0, 0}, '{32'h7fffffff, 0, 0, 0},
                  '{32'h7fffffff, 0, 0, 0}, 1'b1};
      vecs[4] = '{"ovf_sum", '{1, 1, -1, 0}, '{32'h7fffffff, -1, 1, 0},
                  '{32'h7fffffff, -1, -2147483647, 1}, 1'b1};
`else
      vecs[2] = '{"ovf_mul", '{32'h7fffffff, 0, 0, 0}, '{32'h7fffffff, 0, 0, 0},
                  '{1, 0, 0, 0}, 1'b0};
      vecs[4] = '{"ovf_sum", '{1, 1, -1, 0}, '{32'h7fffffff, -1, 1, 0},
                  '{32'h80000000, -1, -2147483647, 1}, 1'b0};
`endif

      u_if.start = 1'b0;
      set_ops(vecs[0]);
      rst = 1'b0;
      repeat (3) tick();
      rst = 1'b1;
      chk("reset.c11",  u_if.c_11, 32'd0);
      chk("reset.c22",  u_if.c_22, 32'd0);
      chk("reset.done", 32'(u_if.done), 32'd0);
      chk("reset.busy", 32'(u_if.busy), 32'd0);
      chk("reset.ovf",  32'(u_if.ovf), 32'd0);
      tick();

      for (int i = 0; i < 5; i++) begin
         run_op(vecs[i]);
         tick();
      end

      // Held start, a lost edge while busy, then a re-raise at minimum spacing
      // with different operands (back-to-back).
      set_ops(vecs[0]);
      u_if.start = 1'b1;
      tick();                               // edge N
      n_done = 0; d0 = -1; d1 = -1; moved = 1'b0;
      for (int e = 1; e <= 25; e++) begin
         u_if.start = (e <= 2) || (e == 4) || (e >= 11 && e <= 13);
         if (e == 11) set_ops(vecs[3]);
         tick();
         if (u_if.done) begin
            if (n_done == 0) d0 = e;
            else             d1 = e;
            n_done++;
         end
         if (e >= 10 && e <= 20 &&
             (u_if.c_11 !== 32'd5 || u_if.c_12 !== 32'd6 ||
              u_if.c_21 !== 32'd7 || u_if.c_22 !== 32'd8)) moved = 1'b1;
      end
      u_if.start = 1'b0;
      chk("held.n_done",   32'(n_done), 32'd2);
      chk("held.done1_at", 32'(d0), 32'd10);
      chk("b2b.done2_at",  32'(d1), 32'd21);
      chk("b2b.c_held",    32'(moved), 32'd0);
      chk_c("b2b", vecs[3]);
      tick();

      // Reset in the middle of an operation.
      set_ops(vecs[1]);
      u_if.start = 1'b1;
      tick();                               // edge N
      u_if.start = 1'b0;
      repeat (4) tick();                    // through edge N+4
      rst = 1'b0;
      tick();                               // edge N+5 with reset
      rst = 1'b1;
      chk("midrst.c11",  u_if.c_11, 32'd0);
      chk("midrst.c12",  u_if.c_12, 32'd0);
      chk("midrst.c21",  u_if.c_21, 32'd0);
      chk("midrst.c22",  u_if.c_22, 32'd0);
      chk("midrst.busy", 32'(u_if.busy), 32'd0);
      chk("midrst.done", 32'(u_if.done), 32'd0);
      n_done = 0;
      for (int e = 0; e < 15; e++) begin
         tick();
         if (u_if.done) n_done++;
      end
      chk("midrst.no_done", 32'(n_done), 32'd0);
      run_op(vecs[1]);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
